// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;
   logic              i_err;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writeData;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_data;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
      output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_address, mem_writeData, mem_read, mem_write
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
      input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_address, mem_writeData, mem_read, mem_write
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (I) and load/store (D).
// Each access is IDLE -> ACCESS -> RESP, with registered memory controls and a one-cycle ack.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | sample requests, pick a port, register memory controls
//   ST_ACCESS | memory controls held; capture read data at end of cycle
//   ST_RESP   | ack (and err) pulse to the granted port
module mem_port_arbiter #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   state_t            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              sel_d_q, sel_d_d;
   logic              err_q, err_d;
   logic              store_q, store_d;

   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_writeData_q, mem_writeData_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;

   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              i_err_q, i_err_d;
   logic              d_err_q, d_err_d;

   logic              i_oor;
   logic              d_oor;
   logic              grant_d;

   assign i_oor = (bus.i_addr >= DEPTH_A);
   assign d_oor = (bus.d_addr >= DEPTH_A);

   always_comb begin
      state_d         = state_q;
      last_d_d        = last_d_q;
      sel_d_d         = sel_d_q;
      err_d           = err_q;
      store_d         = store_q;
      mem_address_d   = mem_address_q;
      mem_writeData_d = mem_writeData_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      i_rdata_d       = i_rdata_q;
      d_rdata_d       = d_rdata_q;
      i_ack_d         = 1'b0;
      d_ack_d         = 1'b0;
      i_err_d         = 1'b0;
      d_err_d         = 1'b0;
      grant_d         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               // D wins when alone, or on contention when I was served last.
               grant_d  = bus.d_req && (!bus.i_req || !last_d_q);
               sel_d_d  = grant_d;
               last_d_d = grant_d;
               state_d  = ST_ACCESS;
               if (grant_d) begin
                  mem_address_d   = bus.d_addr;
                  mem_writeData_d = bus.d_wdata;
                  mem_read_d      = !bus.d_we && !d_oor;
                  mem_write_d     = bus.d_we && !d_oor;
                  err_d           = d_oor;
                  store_d         = bus.d_we;
               end else begin
                  mem_address_d   = bus.i_addr;
                  mem_writeData_d = '0;
                  mem_read_d      = !i_oor;
                  mem_write_d     = 1'b0;
                  err_d           = i_oor;
                  store_d         = 1'b0;
               end
            end
         end

         ST_ACCESS: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            state_d     = ST_RESP;
            if (sel_d_q) begin
               d_ack_d = 1'b1;
               d_err_d = err_q;
               if (!store_q) begin
                  d_rdata_d = err_q ? '0 : bus.mem_data;
               end
            end else begin
               i_ack_d   = 1'b1;
               i_err_d   = err_q;
               i_rdata_d = err_q ? '0 : bus.mem_data;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         last_d_q        <= 1'b0;
         sel_d_q         <= 1'b0;
         err_q           <= 1'b0;
         store_q         <= 1'b0;
         mem_address_q   <= '0;
         mem_writeData_q <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         i_rdata_q       <= '0;
         d_rdata_q       <= '0;
         i_ack_q         <= 1'b0;
         d_ack_q         <= 1'b0;
         i_err_q         <= 1'b0;
         d_err_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_d_q        <= last_d_d;
         sel_d_q         <= sel_d_d;
         err_q           <= err_d;
         store_q         <= store_d;
         mem_address_q   <= mem_address_d;
         mem_writeData_q <= mem_writeData_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         i_rdata_q       <= i_rdata_d;
         d_rdata_q       <= d_rdata_d;
         i_ack_q         <= i_ack_d;
         d_ack_q         <= d_ack_d;
         i_err_q         <= i_err_d;
         d_err_q         <= d_err_d;
      end
   end

   assign bus.i_ack         = i_ack_q;
   assign bus.i_rdata       = i_rdata_q;
   assign bus.i_err         = i_err_q;
   assign bus.d_ack         = d_ack_q;
   assign bus.d_rdata       = d_rdata_q;
   assign bus.d_err         = d_err_q;
   assign bus.mem_address   = mem_address_q;
   assign bus.mem_writeData = mem_writeData_q;
   assign bus.mem_read      = mem_read_q;
   assign bus.mem_write     = mem_write_q;

endmodule
